// File: rtl/coh_pkg.sv
// Shared definitions for the I/S/E write-invalidate coherence protocol:
// line-state encodings, bus and processor message codes, snoop FSM states.
package coh_pkg;

    typedef enum logic [1:0] {
        LS_INVALID   = 2'b00,
        LS_EXCLUSIVE = 2'b01,
        LS_SHARED    = 2'b10
    } line_state_e;

    localparam logic [2:0] BUS_READ_MISS  = 3'b001;
    localparam logic [2:0] BUS_INVALIDATE = 3'b010;
    localparam logic [2:0] BUS_WRITE_MISS = 3'b011;

    typedef enum logic [1:0] {
        SN_IDLE,
        SN_LOOKUP,
        SN_WRITEBACK,
        SN_FINISH
    } snoop_state_e;

    // Processor-side request codes, used by the companion processor-side controller.
    localparam logic [1:0] CPU_READ_HIT   = 2'b00;
    localparam logic [1:0] CPU_READ_MISS  = 2'b01;
    localparam logic [1:0] CPU_WRITE_HIT  = 2'b10;
    localparam logic [1:0] CPU_WRITE_MISS = 2'b11;

    function automatic logic line_hit(input line_state_e st, input logic tag_eq);
        return tag_eq && (st != LS_INVALID);
    endfunction

endpackage

// File: rtl/coh_line_table.sv
// Tag/state storage for the direct-mapped lines: one combinational read port,
// two write ports where a processor update takes priority over a snoop write.
module coh_line_table
    import coh_pkg::*;
#(
    parameter int LINES = 4,
    parameter int TAG_W = 4,
    localparam int IDX_W = $clog2(LINES)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [IDX_W-1:0]  rd_index,
    output logic [TAG_W-1:0]  rd_tag,
    output line_state_e       rd_state,
    input  logic              upd_we,
    input  logic [IDX_W-1:0]  upd_index,
    input  logic [TAG_W-1:0]  upd_tag,
    input  logic [1:0]        upd_state,
    input  logic              snp_we,
    input  logic [IDX_W-1:0]  snp_index,
    input  line_state_e       snp_state
);

    logic [TAG_W-1:0] tags   [LINES];
    line_state_e      states [LINES];

    always_ff @(posedge clock) begin
        for (int i = 0; i < LINES; i++) begin
            if (reset) begin
                tags[i]   <= '0;
                states[i] <= LS_INVALID;
            end else if (upd_we && upd_index == IDX_W'(i)) begin
                tags[i]   <= upd_tag;
                states[i] <= line_state_e'(upd_state);
            end else if (snp_we && snp_index == IDX_W'(i)) begin
                states[i] <= snp_state;
            end
        end
    end

    assign rd_tag   = tags[rd_index];
    assign rd_state = states[rd_index];

endmodule

// File: rtl/coh_snoop_responder.sv
// Bus-side snoop responder: downgrades/invalidates lines and writes back dirty
// Exclusive blocks. Define SNOOP_STATS_EN to add saturating hit/wb/inval counters.
module coh_snoop_responder
    import coh_pkg::*;
#(
    parameter int LINES    = 4,
    parameter int TAG_W    = 4,
    parameter int WB_BEATS = 4,
    localparam int IDX_W   = $clog2(LINES),
    localparam int ADDR_W  = TAG_W + IDX_W,
    localparam int BEAT_W  = (WB_BEATS > 1) ? $clog2(WB_BEATS) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              bus_valid,
    input  logic [2:0]        bus_msg,
    input  logic [ADDR_W-1:0] bus_addr,
    output logic              bus_ready,
    input  logic              upd_valid,
    input  logic [IDX_W-1:0]  upd_index,
    input  logic [TAG_W-1:0]  upd_tag,
    input  logic [1:0]        upd_state,
    output logic              upd_ready,
    output logic              wb_valid,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [BEAT_W-1:0] wb_beat,
    input  logic              wb_ready,
    output logic              snoop_done,
    output logic              snoop_hit,
    output logic              abort_mem,
    output logic              protocol_err
`ifdef SNOOP_STATS_EN
    ,
    output logic [7:0]        stat_hits,
    output logic [7:0]        stat_wbs,
    output logic [7:0]        stat_invals
`endif
);

    snoop_state_e      state_q, state_d;
    logic [2:0]        msg_q;
    logic [ADDR_W-1:0] addr_q;
    logic [BEAT_W-1:0] beat_q, beat_d;
    line_state_e       next_line_q, next_line_d;
    logic              hit_q, hit_d, abort_q, abort_d;
    logic              accept, perr_set, last_beat;
    logic              snp_we;
    line_state_e       snp_state;
    logic [TAG_W-1:0]  rd_tag;
    line_state_e       rd_state;
    logic [IDX_W-1:0]  idx_q;
    logic [TAG_W-1:0]  tag_q;

    assign idx_q     = addr_q[IDX_W-1:0];
    assign tag_q     = addr_q[ADDR_W-1:IDX_W];
    assign last_beat = (beat_q == BEAT_W'(WB_BEATS - 1));
    assign upd_ready = !(state_q != SN_IDLE && upd_index == idx_q);
    assign wb_addr   = addr_q;
    assign wb_beat   = beat_q;

    coh_line_table #(.LINES(LINES), .TAG_W(TAG_W)) u_table (
        .clock     (clock),
        .reset     (reset),
        .rd_index  (idx_q),
        .rd_tag    (rd_tag),
        .rd_state  (rd_state),
        .upd_we    (upd_valid && upd_ready),
        .upd_index (upd_index),
        .upd_tag   (upd_tag),
        .upd_state (upd_state),
        .snp_we    (snp_we),
        .snp_index (idx_q),
        .snp_state (snp_state)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= SN_IDLE;
            msg_q        <= '0;
            addr_q       <= '0;
            beat_q       <= '0;
            next_line_q  <= LS_INVALID;
            hit_q        <= 1'b0;
            abort_q      <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            next_line_q <= next_line_d;
            hit_q       <= hit_d;
            abort_q     <= abort_d;
            if (perr_set) protocol_err <= 1'b1;
            if (accept) begin
                msg_q  <= bus_msg;
                addr_q <= bus_addr;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        next_line_d = next_line_q;
        hit_d       = hit_q;
        abort_d     = abort_q;
        accept      = 1'b0;
        perr_set    = 1'b0;
        snp_we      = 1'b0;
        snp_state   = LS_INVALID;
        bus_ready   = 1'b0;
        wb_valid    = 1'b0;
        snoop_done  = 1'b0;
        snoop_hit   = 1'b0;
        abort_mem   = 1'b0;
        case (state_q)
            SN_IDLE: begin
                bus_ready = 1'b1;
                if (bus_valid) begin
                    accept  = 1'b1;
                    hit_d   = 1'b0;
                    abort_d = 1'b0;
                    state_d = SN_LOOKUP;
                end
            end
            SN_LOOKUP: begin
                hit_d   = line_hit(rd_state, rd_tag == tag_q);
                state_d = SN_FINISH;
                if (hit_d) begin
                    case (rd_state)
                        LS_SHARED: begin
                            if (msg_q == BUS_INVALIDATE || msg_q == BUS_WRITE_MISS) begin
                                snp_we    = 1'b1;
                                snp_state = LS_INVALID;
                            end
                        end
                        LS_EXCLUSIVE: begin
                            if (msg_q == BUS_READ_MISS) begin
                                next_line_d = LS_SHARED;
                                abort_d     = 1'b1;
                                state_d     = SN_WRITEBACK;
                            end else if (msg_q == BUS_WRITE_MISS) begin
                                next_line_d = LS_INVALID;
                                abort_d     = 1'b1;
                                state_d     = SN_WRITEBACK;
                            end else if (msg_q == BUS_INVALIDATE) begin
                                // Another cache cannot own a copy we hold Exclusive.
                                perr_set = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            SN_WRITEBACK: begin
                wb_valid = 1'b1;
                if (wb_ready) begin
                    if (last_beat) begin
                        beat_d    = '0;
                        snp_we    = 1'b1;
                        snp_state = next_line_q;
                        state_d   = SN_FINISH;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            SN_FINISH: begin
                snoop_done = 1'b1;
                snoop_hit  = hit_q;
                abort_mem  = abort_q;
                state_d    = SN_IDLE;
            end
            default: state_d = SN_IDLE;
        endcase
    end

`ifdef SNOOP_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_hits   <= '0;
            stat_wbs    <= '0;
            stat_invals <= '0;
        end else begin
            if (snoop_done && hit_q && stat_hits != 8'hFF)
                stat_hits <= stat_hits + 8'd1;
            if (state_q == SN_WRITEBACK && wb_ready && last_beat && stat_wbs != 8'hFF)
                stat_wbs <= stat_wbs + 8'd1;
            if (snp_we && snp_state == LS_INVALID && stat_invals != 8'hFF)
                stat_invals <= stat_invals + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_coh_snoop_responder.sv
// Directed, table-driven bench for coh_snoop_responder (default parameters),
// plus hand-written update-collision and reset-during-write-back sequences.
module tb_coh_snoop_responder;

    import coh_pkg::*;

    typedef struct {
        logic       do_upd;
        logic       same;
        logic [1:0] uidx;
        logic [3:0] utag;
        logic [1:0] ust;
        logic [2:0] msg;
        logic [3:0] tag;
        logic [1:0] idx;
        int         stall;
        logic       ehit;
        logic       eabort;
        int         ebeats;
        logic       eperr;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       bus_valid;
    logic [2:0] bus_msg;
    logic [5:0] bus_addr;
    logic       bus_ready;
    logic       upd_valid;
    logic [1:0] upd_index;
    logic [3:0] upd_tag;
    logic [1:0] upd_state;
    logic       upd_ready;
    logic       wb_valid;
    logic [5:0] wb_addr;
    logic [1:0] wb_beat;
    logic       wb_ready;
    logic       snoop_done;
    logic       snoop_hit;
    logic       abort_mem;
    logic       protocol_err;

    int n_vectors = 0;
    int n_miscompares = 0;
    vec_t vecs[20];

    coh_snoop_responder dut (
        .clock        (clock),
        .reset        (reset),
        .bus_valid    (bus_valid),
        .bus_msg      (bus_msg),
        .bus_addr     (bus_addr),
        .bus_ready    (bus_ready),
        .upd_valid    (upd_valid),
        .upd_index    (upd_index),
        .upd_tag      (upd_tag),
        .upd_state    (upd_state),
        .upd_ready    (upd_ready),
        .wb_valid     (wb_valid),
        .wb_addr      (wb_addr),
        .wb_beat      (wb_beat),
        .wb_ready     (wb_ready),
        .snoop_done   (snoop_done),
        .snoop_hit    (snoop_hit),
        .abort_mem    (abort_mem),
        .protocol_err (protocol_err)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vectors++;
        if (act !== exp) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic du, input logic same, input logic [1:0] ui,
                                input logic [3:0] ut, input logic [1:0] us, input logic [2:0] m,
                                input logic [3:0] t, input logic [1:0] i, input int st,
                                input logic h, input logic a, input int b, input logic p);
        vec_t v;
        v.do_upd = du; v.same = same; v.uidx = ui; v.utag = ut; v.ust = us;
        v.msg = m; v.tag = t; v.idx = i; v.stall = st;
        v.ehit = h; v.eabort = a; v.ebeats = b; v.eperr = p;
        return v;
    endfunction

    task automatic checkReset(input string pfx);
        checkOutput({pfx, "_bus_ready"}, 32'(bus_ready), 1);
        checkOutput({pfx, "_upd_ready"}, 32'(upd_ready), 1);
        checkOutput({pfx, "_wb_valid"}, 32'(wb_valid), 0);
        checkOutput({pfx, "_wb_beat"}, 32'(wb_beat), 0);
        checkOutput({pfx, "_snoop_done"}, 32'(snoop_done), 0);
        checkOutput({pfx, "_snoop_hit"}, 32'(snoop_hit), 0);
        checkOutput({pfx, "_abort_mem"}, 32'(abort_mem), 0);
        checkOutput({pfx, "_protocol_err"}, 32'(protocol_err), 0);
    endtask

    // Drives one transaction up to acceptance, then follows it to snoop_done,
    // checking each write-back beat, the latency and the completion flags.
    task automatic applyStimulus(input string name, input vec_t v);
        int cyc = 0;
        int nbeats = 0;
        int stall_left = v.stall;
        logic done = 1'b0;
        tick();
        if (v.do_upd) begin
            upd_valid = 1'b1; upd_index = v.uidx; upd_tag = v.utag; upd_state = v.ust;
            if (!v.same) begin
                #1;
                checkOutput({name, "_upd_ready"}, 32'(upd_ready), 1);
                tick();
                upd_valid = 1'b0;
            end
        end
        bus_valid = 1'b1; bus_msg = v.msg; bus_addr = {v.tag, v.idx};
        #1;
        checkOutput({name, "_bus_ready"}, 32'(bus_ready), 1);
        tick();
        bus_valid = 1'b0;
        upd_valid = 1'b0;
        while (!done && cyc < 40) begin
            if (cyc > 0) tick();
            cyc++;
            if (wb_valid) begin
                checkOutput({name, "_wb_beat"}, 32'(wb_beat), 32'(nbeats));
                checkOutput({name, "_wb_addr"}, 32'(wb_addr), 32'({v.tag, v.idx}));
                if (nbeats == 1 && stall_left > 0) begin
                    wb_ready = 1'b0;
                    stall_left--;
                end else begin
                    wb_ready = 1'b1;
                    nbeats++;
                end
            end
            if (snoop_done) done = 1'b1;
        end
        wb_ready = 1'b1;
        checkOutput({name, "_done_seen"}, 32'(done), 1);
        checkOutput({name, "_latency"}, 32'(cyc), 32'(2 + v.ebeats + v.stall));
        checkOutput({name, "_hit"}, 32'(snoop_hit), 32'(v.ehit));
        checkOutput({name, "_abort"}, 32'(abort_mem), 32'(v.eabort));
        checkOutput({name, "_beats"}, 32'(nbeats), 32'(v.ebeats));
        checkOutput({name, "_protocol_err"}, 32'(protocol_err), 32'(v.eperr));
    endtask

    initial begin
        logic done;
        reset = 1'b1; bus_valid = 1'b0; bus_msg = '0; bus_addr = '0;
        upd_valid = 1'b0; upd_index = '0; upd_tag = '0; upd_state = '0; wb_ready = 1'b1;

        // columns: upd?, same-cycle, uidx, utag, ustate, msg, tag, idx, stall, hit, abort, beats, perr
        vecs[0]  = mk(1, 0, 1, 4'h5, 2'b10, 3'b001, 4'h5, 1, 0, 1, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 4'h0, 2'b00, 3'b001, 4'h5, 1, 0, 1, 0, 0, 0);
        vecs[2]  = mk(1, 0, 2, 4'h3, 2'b01, 3'b011, 4'h3, 2, 0, 1, 1, 4, 0);
        vecs[3]  = mk(0, 0, 0, 4'h0, 2'b00, 3'b001, 4'h3, 2, 0, 0, 0, 0, 0);
        vecs[4]  = mk(1, 0, 0, 4'h7, 2'b10, 3'b010, 4'h6, 0, 0, 0, 0, 0, 0);
        vecs[5]  = mk(0, 0, 0, 4'h0, 2'b00, 3'b001, 4'h7, 0, 0, 1, 0, 0, 0);
        vecs[6]  = mk(0, 0, 0, 4'h0, 2'b00, 3'b010, 4'h7, 0, 0, 1, 0, 0, 0);
        vecs[7]  = mk(0, 0, 0, 4'h0, 2'b00, 3'b001, 4'h7, 0, 0, 0, 0, 0, 0);
        vecs[8]  = mk(0, 0, 0, 4'h0, 2'b00, 3'b001, 4'hA, 3, 0, 1, 0, 0, 0);
        vecs[9]  = mk(1, 0, 3, 4'h9, 2'b01, 3'b001, 4'h9, 3, 0, 1, 1, 4, 0);
        vecs[10] = mk(0, 0, 0, 4'h0, 2'b00, 3'b001, 4'h9, 3, 0, 1, 0, 0, 0);
        vecs[11] = mk(0, 0, 0, 4'h0, 2'b00, 3'b111, 4'h9, 3, 0, 1, 0, 0, 0);
        vecs[12] = mk(0, 0, 0, 4'h0, 2'b00, 3'b011, 4'h9, 3, 0, 1, 0, 0, 0);
        vecs[13] = mk(0, 0, 0, 4'h0, 2'b00, 3'b001, 4'h9, 3, 0, 0, 0, 0, 0);
        vecs[14] = mk(1, 0, 2, 4'h4, 2'b01, 3'b001, 4'h4, 2, 3, 1, 1, 4, 0);
        vecs[15] = mk(0, 0, 0, 4'h0, 2'b00, 3'b001, 4'h4, 2, 0, 1, 0, 0, 0);
        vecs[16] = mk(1, 1, 0, 4'h2, 2'b01, 3'b011, 4'h2, 0, 0, 1, 1, 4, 0);
        vecs[17] = mk(0, 0, 0, 4'h0, 2'b00, 3'b001, 4'h2, 0, 0, 0, 0, 0, 0);
        vecs[18] = mk(1, 0, 1, 4'h5, 2'b00, 3'b001, 4'h5, 1, 0, 0, 0, 0, 0);
        vecs[19] = mk(1, 0, 1, 4'h2, 2'b01, 3'b010, 4'h2, 1, 0, 1, 0, 0, 1);

        repeat (2) tick();
        checkReset("rst");
        reset = 1'b0;

        // Updates during a write-back: the busy index is refused, others go straight in.
        tick();
        upd_valid = 1'b1; upd_index = 2; upd_tag = 4'h3; upd_state = 2'b01;
        tick();
        upd_valid = 1'b0;
        wb_ready = 1'b0;
        bus_valid = 1'b1; bus_msg = 3'b011; bus_addr = {4'h3, 2'd2};
        tick();
        bus_valid = 1'b0;
        tick();
        tick();
        checkOutput("coll_wb_valid", 32'(wb_valid), 1);
        upd_valid = 1'b1; upd_index = 2; upd_tag = 4'h1; upd_state = 2'b10;
        #1;
        checkOutput("coll_upd_ready_busy", 32'(upd_ready), 0);
        upd_index = 3; upd_tag = 4'hA; upd_state = 2'b10;
        #1;
        checkOutput("coll_upd_ready_other", 32'(upd_ready), 1);
        tick();
        upd_valid = 1'b0;
        checkOutput("coll_wb_beat_held", 32'(wb_beat), 0);
        wb_ready = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            tick();
            if (snoop_done) done = 1'b1;
        end
        checkOutput("coll_done_seen", 32'(done), 1);
        checkOutput("coll_hit", 32'(snoop_hit), 1);
        checkOutput("coll_abort", 32'(abort_mem), 1);

        for (int i = 0; i < 20; i++)
            applyStimulus($sformatf("vec%0d", i), vecs[i]);

        // Reset while a write-back is in flight on the still-Exclusive line 1.
        tick();
        bus_valid = 1'b1; bus_msg = 3'b001; bus_addr = {4'h2, 2'd1};
        tick();
        bus_valid = 1'b0;
        tick();
        tick();
        checkOutput("rwb_wb_valid", 32'(wb_valid), 1);
        checkOutput("rwb_wb_beat", 32'(wb_beat), 1);
        checkOutput("rwb_protocol_err", 32'(protocol_err), 1);
        reset = 1'b1;
        tick();
        checkReset("rwb");
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("rwb_no_done", 32'(snoop_done), 0);
        end
        applyStimulus("post_rst_l1", mk(0, 0, 0, 4'h0, 2'b00, 3'b001, 4'h2, 1, 0, 0, 0, 0, 0));
        applyStimulus("post_rst_l2", mk(0, 0, 0, 4'h0, 2'b00, 3'b001, 4'h4, 2, 0, 0, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
